instr_word_builder: RTL and testbench
=====================================

# instr_word_builder

Instruction-word encoder and loader: the inverse of the `main_control` opcode decoder. It accepts field-level instruction descriptors (type, registers, funct, immediate) over a valid/ready handshake, assembles each into a 32-bit RV32I word for the five types the decoder supports, and writes the words sequentially into the instruction-memory write port. It sits between the test/boot loader and the instruction memory, so the memory always holds opcodes the control decoder recognises.

## Interface
- `DEPTH`, 64: instruction-memory words; `ADDR_W = $clog2(DEPTH)`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: synchronous restart of the address, count and error flag; lower priority than `reset`.
- `in_valid` in 1: descriptor valid.
- `in_ready` out 1: builder can accept.
- `in_type` in 3: instruction class, encoded per the package.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_funct3` in 3; `in_funct7` in 7.
- `in_imm` in 13: signed immediate; bits [11:0] for I/LOAD/S; bits [12:1] for B (bit 0 ignored).
- `imem_we` out 1: write strobe.
- `imem_addr` out ADDR_W: word address.
- `imem_wdata` out 32: encoded instruction.
- `count` out ADDR_W+1: words written since reset/clear.
- `full` out 1: DEPTH words written.
- `err` out 1: sticky; an invalid `in_type` was accepted.

## Operation
- Package types: `TYPE_R=0`, `TYPE_I=1`, `TYPE_LOAD=2`, `TYPE_S=3`, `TYPE_B=4`; values 5–7 are invalid.
- Encodings:
  - R: funct7|rs2|rs1|funct3|rd|0110011.
  - I: imm[11:0]|rs1|funct3|rd|0010011.
  - LOAD: as I with opcode 0000011.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011.
- Fields unused by a type are ignored (for example, funct7 for I, rd for S/B).
- FSM states: ACCEPT, WRITE, FULL.
  - ACCEPT: `in_ready=1`. On `in_valid`, register the encoded word.
    - Valid type: go to WRITE.
    - Invalid type: set `err`, stay in ACCEPT, no write, address unchanged.
  - WRITE: `in_ready=0`, `imem_we=1` with the registered word at `imem_addr`. At the end of the cycle, increment `imem_addr` and `count`.
    - If `count` reaches DEPTH: go to FULL.
    - Otherwise: return to ACCEPT.
  - FULL: `in_ready=0`, `full=1`, `imem_we=0`. Leave only on `clear` or `reset`.
- `clear` in any state: go to ACCEPT; address, `count` and `err` become 0. A `clear` in WRITE suppresses that cycle's `imem_we`.
- `reset` mid-write: same as `clear`, and `imem_wdata` also goes to 0.

## Timing
- Reset values: `in_ready=1`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `count=0`, `full=0`, `err=0`.
- Handshake at edge N (`in_valid & in_ready`): `imem_we=1` during cycle N→N+1, then `in_ready=1` again from N+1.
- Throughput: one word per 2 cycles. Latency: 1 cycle from accept to write strobe.
- `imem_wdata` is registered and holds its last value while `imem_we=0`.
- `imem_addr` never wraps; the DEPTH-th write forces FULL.
- `err` is only observable and cleared as above; it does not block acceptance.
- `in_valid` asserted while `in_ready=0` is ignored. The descriptor is not latched, and the source must hold it.

## Structure
- `rv_instr_pkg` holds:
  - `instr_type_e` (the `TYPE_*` values above);
  - opcode constants `OP_R=7'b0110011`, `OP_I=7'b0010011`, `OP_LOAD=7'b0000011`, `OP_S=7'b0100011`, `OP_B=7'b1100011`.
- These opcode constants are shared with `main_control` so that encoder and decoder agree on opcodes.
- One combinational sub-module, `instr_encode`: descriptor in, 32-bit word plus a `type_valid` flag out.
- The top-level module holds the FSM, the address/count registers and the output registers.

## Test plan
- R `add x3,x1,x2` (funct3=0, funct7=0): `imem_we` pulse at addr 0 with `0x002081B3`; `count=1`.
- I `addi x5,x0,-1` then LOAD `lw x6,8(x2)`: addr 0 gets `0xFFF00293`, addr 1 gets `0x00812303`; `in_ready` low exactly one cycle after each accept.
- S `sw x6,12(x2)` gets `0x00612623`; B `beq x1,x2,-4` gets `0xFE208EE3`. With `in_imm[0]=1` the B word is unchanged.
- `in_type=7`: accepted, `err=1`, no `imem_we`. The following valid R descriptor is still written at the same address.
- DEPTH=4 with back-to-back valid descriptors: 4 writes at addresses 0–3, then `full=1` and `in_ready=0`. A fifth descriptor is held off. `clear` gives `count=0`, `imem_addr=0`, `in_ready=1`.
- `clear` asserted in the WRITE cycle: no `imem_we` that cycle, and `imem_addr` stays 0. Repeat with `reset`: all outputs take their reset values.

Source files
------------

// File: rtl/rv_instr_pkg.sv
// Shared RV32I instruction-class and opcode definitions, used by both the
// word builder and the main_control decoder so encoder and decoder agree.
package rv_instr_pkg;

  typedef enum logic [2:0] {
    TYPE_R    = 3'd0,
    TYPE_I    = 3'd1,
    TYPE_LOAD = 3'd2,
    TYPE_S    = 3'd3,
    TYPE_B    = 3'd4
  } instr_type_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I encoder: field descriptor in, 32-bit word out.
// type_valid is low for the unsupported classes 5..7 (word is then zero).
module instr_encode
  import rv_instr_pkg::*;
(
  input  logic [2:0]  in_type,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [12:0] in_imm,
  output logic [31:0] word,
  output logic        type_valid
);

  always_comb begin
    word       = 32'd0;
    type_valid = 1'b1;
    case (in_type)
      TYPE_R:    word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      TYPE_I:    word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
      TYPE_LOAD: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      TYPE_S:    word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
      // Branch offsets are halfword aligned, so imm[0] is dropped.
      TYPE_B:    word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], OP_B};
      default:   type_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_word_builder.sv
// Accepts instruction descriptors, encodes them and writes the words to
// consecutive instruction-memory addresses until DEPTH words are stored.
module instr_word_builder
  import rv_instr_pkg::*;
#(
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_type_valid;
  logic        accept;

  instr_encode u_encode (
    .in_type    (in_type),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .word       (enc_word),
    .type_valid (enc_type_valid)
  );

  // Handshake: a descriptor transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on state, and a clear or
  // reset on that same edge discards the transfer.
  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_ACCEPT: begin
        if (accept) begin
          if (enc_type_valid) begin
            wdata_d = enc_word;
            state_d = ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        // The address saturates on the last word instead of wrapping to 0.
        if (count_d == DEPTH_CNT) begin
          state_d = ST_FULL;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_ACCEPT;
        end
      end
      ST_FULL:  state_d = ST_FULL;
      default:  state_d = ST_ACCEPT;
    endcase
    if (clear) begin
      state_d = ST_ACCEPT;
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCEPT;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == ST_ACCEPT);
  assign imem_we    = (state_q == ST_WRITE) & ~clear & ~reset;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = (state_q == ST_FULL);
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_word_builder.sv
// Directed bench for instr_word_builder (DEPTH=4): expected writes go into a
// queue at accept time and are popped by a monitor on every imem_we strobe.
module tb_instr_word_builder;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = 32 + AW;

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, in_ready;
  logic [2:0]    in_type, in_funct3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [6:0]    in_funct7;
  logic [12:0]   in_imm;
  logic          imem_we, full, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic [1:0]    dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_addr = 0;

  always #5 clk = ~clk;

  instr_word_builder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", 64'(imem_we), 64'd0);
      else check("imem_write", 64'({imem_addr, imem_wdata}), 64'(exp_q.pop_front()));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] imm, input bit push, input logic [31:0] word);
    int n = 0;
    in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back({AW'(exp_addr), word});
      exp_addr++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    exp_addr = 0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    check({pfx, "_imem_we"}, 64'(imem_we), 64'd0);
    check({pfx, "_imem_addr"}, 64'(imem_addr), 64'd0);
    check({pfx, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({pfx, "_count"}, 64'(count), 64'd0);
    check({pfx, "_full"}, 64'(full), 64'd0);
    check({pfx, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_type = 3'd0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    cycles(2);
    check_reset_values("reset");
    reset = 1'b0;

    // R: add x3,x1,x2
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 32'h002081B3);
    cycles(1);
    check("r_count", 64'(count), 64'd1);
    check("r_ready_back", 64'(in_ready), 64'd1);
    do_clear();

    // I: addi x5,x0,-1 (funct7 is junk and must be ignored); LOAD: lw x6,8(x2)
    send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'h7F, 13'h1FFF, 1'b1, 32'hFFF00293);
    check("i_ready_low", 64'(in_ready), 64'd0);
    cycles(1);
    check("i_ready_high", 64'(in_ready), 64'd1);
    send(3'd2, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8, 1'b1, 32'h00812303);
    check("load_ready_low", 64'(in_ready), 64'd0);
    cycles(1);
    check("load_ready_high", 64'(in_ready), 64'd1);
    check("load_count", 64'(count), 64'd2);
    do_clear();

    // S: sw x6,12(x2) with junk rd; B: beq x1,x2,-4, then again with imm[0]=1
    send(3'd3, 5'd31, 5'd2, 5'd6, 3'd2, 7'd0, 13'd12, 1'b1, 32'h00612623);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC, 1'b1, 32'hFE208EE3);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFD, 1'b1, 32'hFE208EE3);
    cycles(1);
    check("sb_count", 64'(count), 64'd3);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    do_clear();

    // Invalid type: accepted, err set, no write; next R lands at address 0
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0, 1'b0, 32'd0);
    check("inv_err", 64'(err), 64'd1);
    check("inv_ready", 64'(in_ready), 64'd1);
    check("inv_count", 64'(count), 64'd0);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 32'h002081B3);
    cycles(1);
    check("inv_next_count", 64'(count), 64'd1);
    check("inv_err_sticky", 64'(err), 64'd1);
    do_clear();
    check("clear_err", 64'(err), 64'd0);

    // Fill to DEPTH with back-to-back R descriptors
    for (int i = 0; i < DEPTH; i++) begin
      send(3'd0, 5'(i + 1), 5'(i), 5'(i + 2), 3'd0, 7'd0, 13'd0, 1'b1,
           {7'd0, 5'(i + 2), 5'(i), 3'd0, 5'(i + 1), 7'h33});
    end
    cycles(1);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(in_ready), 64'd0);
    check("fill_count", 64'(count), 64'(DEPTH));
    in_type = 3'd0; in_rd = 5'd9; in_rs1 = 5'd9; in_rs2 = 5'd9; in_valid = 1'b1;
    cycles(3);
    check("held_ready", 64'(in_ready), 64'd0);
    check("held_count", 64'(count), 64'(DEPTH));
    check("held_drained", 64'(exp_q.size()), 64'd0);
    in_valid = 1'b0;
    do_clear();
    check("clr_count", 64'(count), 64'd0);
    check("clr_addr", 64'(imem_addr), 64'd0);
    check("clr_ready", 64'(in_ready), 64'd1);
    check("clr_full", 64'(full), 64'd0);

    // clear during WRITE suppresses the strobe
    send(3'd0, 5'd7, 5'd7, 5'd7, 3'd0, 7'd0, 13'd0, 1'b0, 32'd0);
    clear = 1'b1;
    #1;
    check("cw_we", 64'(imem_we), 64'd0);
    cycles(1);
    clear = 1'b0;
    check("cw_addr", 64'(imem_addr), 64'd0);
    check("cw_count", 64'(count), 64'd0);
    check("cw_ready", 64'(in_ready), 64'd1);

    // reset during WRITE: everything back to reset values, wdata included
    send(3'd0, 5'd8, 5'd8, 5'd8, 3'd0, 7'd0, 13'd0, 1'b0, 32'd0);
    reset = 1'b1;
    #1;
    check("rw_we", 64'(imem_we), 64'd0);
    cycles(1);
    reset = 1'b0;
    check_reset_values("rw");

    cycles(2);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
